alp_seq_unit: RTL and testbench

//  Parametrised multi-register arithmetic/logic processor; successor to the 4-bit two-output ALP.

---
 rtl/alp_seq_unit.sv | 163 ++++++++++++++++
 tb/tb_alp_seq_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alp_seq_unit.sv
// Multi-register arithmetic/logic scratch unit: one command per handshake, single-cycle ALU ops,
// an iterative shift-add multiply and a sticky error flag, with two combinational read ports.
module alp_seq_unit #(
   parameter int W    = 4,
   parameter int NREG = 4,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    op,
   input  logic          load,
   input  logic          comp,
   input  logic          clr,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] src,
   input  logic [W-1:0]  data_in,
   input  logic [AW-1:0] rd_a,
   input  logic [AW-1:0] rd_b,
   output logic [W-1:0]  out_a,
   output logic [W-1:0]  out_b,
   output logic          done,
   output logic          err,
   output logic [1:0]    dbg_state
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL1 = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;
   localparam int         CW      = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    regs [NREG];
   logic [2:0]      op_q;
   logic            load_q, comp_q, clr_q;
   logic [AW-1:0]   dst_q;
   logic [W-1:0]    data_q, a_q, b_q;
   logic [2*W-1:0]  mcand_q, prod_q, prod_nxt;
   logic [CW-1:0]   cnt_q;
   logic            accept, start_mul, mul_last;
   logic [W:0]      sum_w;
   logic [W-1:0]    alu_res;
   logic            alu_err;

   // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
   // cmd_ready depends only on state, never on cmd_valid, and all fields are captured at that edge.
   assign accept    = cmd_valid & (state == IDLE);
   assign start_mul = comp & ~load & ~clr & (op == OP_MUL);
   assign mul_last  = (cnt_q == LAST);
   assign dbg_state = state;
   assign out_a     = regs[rd_a];
   assign out_b     = regs[rd_b];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = start_mul ? MUL : EXEC;
         end
         EXEC:    state_nxt = IDLE;
         MUL:     if (mul_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
   // b_q doubles as the multiplier and is shifted right one bit per MUL cycle.
   assign prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);

   always_comb begin
      alu_res = a_q;
      alu_err = 1'b0;
      case (op_q)
         OP_ADD:  begin alu_res = sum_w[W-1:0]; alu_err = sum_w[W]; end
         OP_SUB:  begin alu_res = a_q - b_q; alu_err = (a_q < b_q); end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SHL1: begin alu_res = {a_q[W-2:0], 1'b0}; alu_err = a_q[W-1]; end
         OP_PASS: alu_res = b_q;
         default: alu_res = a_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
         op_q    <= '0;
         load_q  <= 1'b0;
         comp_q  <= 1'b0;
         clr_q   <= 1'b0;
         dst_q   <= '0;
         data_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               op_q    <= op;
               load_q  <= load;
               comp_q  <= comp;
               clr_q   <= clr;
               dst_q   <= dst;
               data_q  <= data_in;
               a_q     <= regs[dst];
               b_q     <= regs[src];
               mcand_q <= {{W{1'b0}}, regs[dst]};
               prod_q  <= '0;
               cnt_q   <= '0;
            end
            EXEC: begin
               done <= 1'b1;
               if (clr_q) begin
                  for (int i = 0; i < NREG; i++) regs[i] <= '0;
                  err <= 1'b0;
               end else if (load_q && comp_q) begin
                  err <= 1'b1;
               end else if (load_q) begin
                  regs[dst_q] <= data_q;
               end else if (comp_q) begin
                  regs[dst_q] <= alu_res;
                  if (alu_err) err <= 1'b1;
               end
            end
            MUL: begin
               prod_q  <= prod_nxt;
               mcand_q <= mcand_q << 1;
               b_q     <= b_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (mul_last) begin
                  regs[dst_q] <= prod_nxt[W-1:0];
                  if (|prod_nxt[2*W-1:W]) err <= 1'b1;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alp_seq_unit.sv
// Bench for alp_seq_unit: directed vector table, held-valid and reset-abort sequences,
// then random commands against an arithmetic reference model.
module tb_alp_seq_unit;
   localparam int W = 4;
   localparam int NREG = 4;
   localparam int AW = 2;
   localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3;
   localparam logic [2:0] T_XOR = 3'd4, T_SHL = 3'd5, T_MUL = 3'd6, T_PASS = 3'd7;

   logic          clk = 1'b0;
   logic          reset, cmd_valid, cmd_ready, load, comp, clr, done, err;
   logic [2:0]    op;
   logic [AW-1:0] dst, src, rd_a, rd_b;
   logic [W-1:0]  data_in, out_a, out_b;
   logic [1:0]    dbg_state;

   int tests = 0;
   int fails = 0;
   int acc_cnt = 0;
   int model [NREG];
   int model_err = 0;
   logic [W-1:0] exp_q [$];

   typedef struct {
      logic [2:0]    op;
      logic          ld, cp, cl;
      logic [AW-1:0] dst, src;
      logic [W-1:0]  data;
      logic [W-1:0]  exp_val;
      logic          exp_err;
      int            exp_busy;
   } vec_t;
   vec_t vecs [$];

   always #5 clk = ~clk;

   alp_seq_unit #(.W(W), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .op(op),
      .load(load), .comp(comp), .clr(clr), .dst(dst), .src(src), .data_in(data_in),
      .rd_a(rd_a), .rd_b(rd_b), .out_a(out_a), .out_b(out_b), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   always @(posedge clk) if (reset && cmd_valid && cmd_ready) acc_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Reference: exact integer result, error whenever it falls outside 0..2^W-1.
   function automatic void model_apply(input logic [2:0] o, input logic ld, cp, cl,
                                       input int d, s, dat);
      int a, b, r, mask;
      mask = (1 << W) - 1;
      if (cl) begin
         for (int i = 0; i < NREG; i++) model[i] = 0;
         model_err = 0;
      end else if (ld && cp) begin
         model_err = 1;
      end else if (ld) begin
         model[d] = dat;
      end else if (cp) begin
         a = model[d];
         b = model[s];
         case (o)
            T_ADD:   r = a + b;
            T_SUB:   r = a - b;
            T_AND:   r = a & b;
            T_OR:    r = a | b;
            T_XOR:   r = a ^ b;
            T_SHL:   r = a * 2;
            T_MUL:   r = a * b;
            default: r = b;
         endcase
         if (r < 0 || r > mask) model_err = 1;
         model[d] = r & mask;
      end
   endfunction

   task automatic run_cmd(input logic [2:0] o, input logic ld, cp, cl, input logic [AW-1:0] d, s,
                          input logic [W-1:0] dat, output int busy, output bit got_done);
      int n;
      @(negedge clk);
      op = o; load = ld; comp = cp; clr = cl; dst = d; src = s; data_in = dat;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      op = 3'($urandom_range(0, 7));
      load = 1'($urandom_range(0, 1));
      comp = 1'($urandom_range(0, 1));
      clr = 1'($urandom_range(0, 1));
      dst = AW'($urandom_range(0, NREG - 1));
      src = AW'($urandom_range(0, NREG - 1));
      data_in = W'($urandom_range(0, (1 << W) - 1));
      busy = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (!cmd_ready) busy++;
      end
      if (got_done) begin
         chk("ready_in_done_cycle", 32'(cmd_ready), 32'd1);
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
      end
   endtask

   task automatic check_regs(input string tag);
      @(negedge clk);
      for (int i = 0; i < NREG; i++) begin
         exp_q.push_back(W'(model[i]));
         rd_a = AW'(i);
         rd_b = AW'(NREG - 1 - i);
         #1;
         chk({tag, "_rd_a"}, 32'(out_a), 32'(exp_q.pop_front()));
         chk({tag, "_rd_b"}, 32'(out_b), 32'(model[NREG - 1 - i]));
      end
      chk({tag, "_err"}, 32'(err), 32'(model_err));
   endtask

   task automatic add(input logic [2:0] o, input logic ld, cp, cl, input int d, s, dat, ev,
                      input logic ee, input int eb);
      vec_t v;
      v.op = o; v.ld = ld; v.cp = cp; v.cl = cl;
      v.dst = AW'(d); v.src = AW'(s); v.data = W'(dat);
      v.exp_val = W'(ev); v.exp_err = ee; v.exp_busy = eb;
      vecs.push_back(v);
   endtask

   initial begin
      int  busy;
      bit  got;
      bit  seen;
      int  kind;
      logic [2:0] r_op;
      logic r_ld, r_cp, r_cl;
      logic [AW-1:0] r_d, r_s;
      logic [W-1:0] r_dat;

      for (int i = 0; i < NREG; i++) model[i] = 0;
      reset = 1'b0; cmd_valid = 1'b0; op = '0; load = 1'b0; comp = 1'b0; clr = 1'b0;
      dst = '0; src = '0; data_in = '0; rd_a = 2'd1; rd_b = 2'd2;

      // reset held three cycles, then released
      repeat (3) @(negedge clk);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_done", 32'(done), 32'd0);

      //  op     ld    cp    cl   dst src dat  val err busy
      add(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 9,   9, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 8,   8, 1'b0, 1);
      add(T_ADD, 1'b0, 1'b1, 1'b0, 1, 2, 0,   1, 1'b1, 1);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 1, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 2,   2, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 5,   5, 1'b0, 1);
      add(T_SUB, 1'b0, 1'b1, 1'b0, 1, 2, 0,  13, 1'b1, 1);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 0, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 3,   3, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 5,   5, 1'b0, 1);
      add(T_MUL, 1'b0, 1'b1, 1'b0, 1, 2, 0,  15, 1'b0, 4);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 4,   4, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 4,   4, 1'b0, 1);
      add(T_MUL, 1'b0, 1'b1, 1'b0, 1, 2, 0,   0, 1'b1, 4);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 0, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 0, 0, 6,   6, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b1, 1'b0, 0, 0, 9,   6, 1'b1, 1);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 0, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 3, 0, 10, 10, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 12, 12, 1'b0, 1);
      add(T_AND, 1'b0, 1'b1, 1'b0, 3, 2, 0,   8, 1'b0, 1);
      add(T_OR,  1'b0, 1'b1, 1'b0, 3, 2, 0,  12, 1'b0, 1);
      add(T_XOR, 1'b0, 1'b1, 1'b0, 3, 2, 0,   0, 1'b0, 1);
      add(T_PASS,1'b0, 1'b1, 1'b0, 3, 2, 0,  12, 1'b0, 1);
      add(T_SHL, 1'b0, 1'b1, 1'b0, 3, 0, 0,   8, 1'b1, 1);
      add(T_SHL, 1'b0, 1'b1, 1'b0, 3, 0, 0,   0, 1'b1, 1);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 0, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 0, 0, 7,   7, 1'b0, 1);
      add(T_ADD, 1'b0, 1'b1, 1'b0, 0, 0, 0,  14, 1'b0, 1);
      add(T_ADD, 1'b0, 1'b0, 1'b0, 0, 0, 0,  14, 1'b0, 1);
      add(T_SHL, 1'b0, 1'b1, 1'b0, 0, 0, 0,  12, 1'b1, 1);
      add(T_MUL, 1'b0, 1'b1, 1'b0, 0, 0, 0,   0, 1'b1, 4);
      add(T_ADD, 1'b0, 1'b0, 1'b1, 0, 0, 0,   0, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 15, 15, 1'b0, 1);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 1,   1, 1'b0, 1);
      add(T_MUL, 1'b0, 1'b1, 1'b0, 1, 2, 0,  15, 1'b0, 4);
      add(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 0,   0, 1'b0, 1);
      add(T_MUL, 1'b0, 1'b1, 1'b0, 1, 2, 0,   0, 1'b0, 4);

      foreach (vecs[k]) begin
         run_cmd(vecs[k].op, vecs[k].ld, vecs[k].cp, vecs[k].cl, vecs[k].dst, vecs[k].src,
                 vecs[k].data, busy, got);
         chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
         chk($sformatf("vec%0d_done", k), 32'(got), 32'd1);
         @(negedge clk);
         rd_a = vecs[k].dst;
         #1;
         chk($sformatf("vec%0d_val", k), 32'(out_a), 32'(vecs[k].exp_val));
         chk($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
         model_apply(vecs[k].op, vecs[k].ld, vecs[k].cp, vecs[k].cl, vecs[k].dst, vecs[k].src,
                     vecs[k].data);
         check_regs($sformatf("vec%0d", k));
      end

      // command held valid while a MUL is busy: accepted once, in the MUL's done cycle
      run_cmd(T_ADD, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 4'd3, busy, got);
      model_apply(T_ADD, 1'b1, 1'b0, 1'b0, 1, 0, 3);
      run_cmd(T_ADD, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 4'd5, busy, got);
      model_apply(T_ADD, 1'b1, 1'b0, 1'b0, 2, 0, 5);
      @(negedge clk);
      acc_cnt = 0;
      op = T_MUL; load = 1'b0; comp = 1'b1; clr = 1'b0; dst = 2'd1; src = 2'd2; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      model_apply(T_MUL, 1'b0, 1'b1, 1'b0, 1, 2, 0);
      op = T_ADD; dst = 2'd2; src = 2'd2;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
         busy++;
      end
      chk("held_busy_cycles", 32'(busy), 32'd4);
      chk("held_mul_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      chk("held_add_done", 32'(got), 32'd1);
      model_apply(T_ADD, 1'b0, 1'b1, 1'b0, 2, 2, 0);
      repeat (3) @(negedge clk);
      chk("held_accept_count", 32'(acc_cnt), 32'd2);
      check_regs("held");

      // random commands against the reference model
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 19);
         r_op = 3'($urandom_range(0, 7));
         r_d = AW'($urandom_range(0, NREG - 1));
         r_s = AW'($urandom_range(0, NREG - 1));
         r_dat = W'($urandom_range(0, (1 << W) - 1));
         r_cl = (kind == 0);
         r_ld = (kind == 1) || (kind >= 3 && kind <= 8);
         r_cp = (kind == 1) || (kind >= 9);
         run_cmd(r_op, r_ld, r_cp, r_cl, r_d, r_s, r_dat, busy, got);
         chk("rand_busy", 32'(busy),
             (r_cp && !r_ld && !r_cl && r_op == T_MUL) ? 32'(W) : 32'd1);
         chk("rand_done", 32'(got), 32'd1);
         model_apply(r_op, r_ld, r_cp, r_cl, r_d, r_s, r_dat);
         check_regs($sformatf("rand%0d", n));
      end

      // reset asserted in the second MUL cycle aborts the multiply
      run_cmd(T_ADD, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 4'd3, busy, got);
      run_cmd(T_ADD, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 4'd5, busy, got);
      @(negedge clk);
      op = T_MUL; load = 1'b0; comp = 1'b1; clr = 1'b0; dst = 2'd1; src = 2'd2; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_err", 32'(err), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < NREG; i++) model[i] = 0;
      model_err = 0;
      check_regs("abort");
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_idle_ready", 32'(cmd_ready), 32'd1);
      check_regs("abort_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
